// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, in-order imem reads, FWFT instruction buffer to decode.
// Optional FETCH_NOP_SQUASH_EN drops nop (opcode 2'b10) responses before decode.
module fetch_stage #(
  parameter int IW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rsp_valid,
  input  logic [IW-1:0] imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_target,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [IW-1:0] id_instr,
  output logic [AW-1:0] id_pc,
  output logic [1:0]    id_opcode
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } fq_t;

  logic [AW-1:0] pc;
  logic [CW-1:0] o_cnt;
  logic [CW-1:0] d_cnt;
  logic [CW-1:0] n_cnt;

  fq_t           fq [DEPTH];
  logic [PW-1:0] fq_wr;
  logic [PW-1:0] fq_rd;

  logic [AW-1:0] aq [DEPTH];
  logic [PW-1:0] aq_wr;
  logic [PW-1:0] aq_rd;

  logic [CW:0]   credit;
  logic          issue;
  logic          take;
  logic          squash;
  logic          push;
  logic          pop;
  fq_t           head;

  always_comb begin
    credit = {1'b0, o_cnt} + {1'b0, n_cnt};
    issue  = reset_n && !redirect_valid
           && (credit < (CW+1)'(DEPTH));
    // stale responses never consume an address-queue slot
    take   = imem_rsp_valid && !redirect_valid
           && (d_cnt == '0);
`ifdef FETCH_NOP_SQUASH_EN
    squash = (imem_rsp_data[IW-1 -: 2] == 2'b10);
`else
    squash = 1'b0;
`endif
    push     = take && !squash;
    id_valid = (n_cnt != '0) && !redirect_valid;
    pop      = id_valid && id_ready;
  end

  assign imem_req  = issue;
  assign imem_addr = pc;

  assign head      = fq[fq_rd];
  assign id_instr  = (n_cnt != '0) ? head.instr : '0;
  assign id_pc     = (n_cnt != '0) ? head.pc : '0;
  assign id_opcode = id_instr[IW-1 -: 2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= '0;
      o_cnt <= '0;
      d_cnt <= '0;
      n_cnt <= '0;
      fq_wr <= '0;
      fq_rd <= '0;
      aq_wr <= '0;
      aq_rd <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_target;
      o_cnt <= o_cnt - CW'(imem_rsp_valid);
      d_cnt <= o_cnt - CW'(imem_rsp_valid);
      n_cnt <= '0;
      fq_wr <= '0;
      fq_rd <= '0;
      aq_wr <= '0;
      aq_rd <= '0;
    end else begin
      if (issue) begin
        pc    <= pc + AW'(1);
        aq_wr <= aq_wr + PW'(1);
      end
      o_cnt <= o_cnt + CW'(issue) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (d_cnt != '0))
        d_cnt <= d_cnt - CW'(1);
      if (take)
        aq_rd <= aq_rd + PW'(1);
      if (push)
        fq_wr <= fq_wr + PW'(1);
      if (pop)
        fq_rd <= fq_rd + PW'(1);
      n_cnt <= n_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (issue)
      aq[aq_wr] <= pc;
    if (push)
      fq[fq_wr] <= '{instr: imem_rsp_data, pc: aq[aq_rd]};
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage.
// Expected decode stream is the program order from the last reset/redirect.
module tb_fetch_stage;

  localparam int IW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          id_valid;
  logic          id_ready;
  logic [IW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic [1:0]    id_opcode;

  always #5 clk = ~clk;

  fetch_stage #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_opcode       (id_opcode)
  );

  typedef struct {
    logic [7:0] addr;
    int         due;
  } mreq_t;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] instr;
  } exp_t;

  mreq_t      mq[$];
  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] mem [256];
  int         lat;
  int         cyc;
  int         n_cmp;
  int         n_bad;
  int         req_cnt;
  bit         hold;
  logic [7:0] hpc;
  logic [7:0] hin;

  function automatic bit is_nop(input logic [7:0] v);
`ifdef FETCH_NOP_SQUASH_EN
    return v[7:6] == 2'b10;
`else
    return 1'b0;
`endif
  endfunction

  task automatic fill(input logic [7:0] start);
    logic [7:0] p;
    p = start;
    exp_q.delete();
    for (int i = 0; i < 1024 && exp_q.size() < 512; i++) begin
      if (!is_nop(mem[p]))
        exp_q.push_back('{pc: p, instr: mem[p]});
      p = p + 8'd1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic respond();
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem[mq[0].addr];
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 8'($urandom);
    end
  endtask

  task automatic step(input bit rv, input logic [7:0] tgt, input bit rdy);
    @(negedge clk);
    cyc++;
    respond();
    redirect_valid  = rv;
    redirect_target = tgt;
    id_ready        = rdy;
    if (rv)
      fill(tgt);
    #1;
    if (imem_req)
      mq.push_back('{addr: imem_addr, due: cyc + lat});
  endtask

  task automatic do_reset(input int l, input bit rdy);
    reset_n = 1'b0;
    lat     = l;
    repeat (3) begin
      @(negedge clk);
      mq.delete();
      imem_rsp_valid  = 1'($urandom);
      imem_rsp_data   = 8'($urandom);
      redirect_valid  = 1'($urandom);
      redirect_target = 8'($urandom);
      id_ready        = 1'($urandom);
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_valid", id_valid, 0);
      chk("rst_instr", id_instr, 0);
      chk("rst_pc", id_pc, 0);
      chk("rst_opcode", id_opcode, 0);
    end
    @(negedge clk);
    mq.delete();
    reset_n        = 1'b1;
    cyc            = 0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = rdy;
    fill(8'd0);
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    if (imem_req)
      mq.push_back('{addr: imem_addr, due: cyc + lat});
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset_n) begin
      hold = 1'b0;
    end else begin
      if (redirect_valid)
        chk("redir_no_valid", id_valid, 0);
      if (hold && !redirect_valid) begin
        chk("hold_valid", id_valid, 1);
        chk("hold_pc", id_pc, hpc);
        chk("hold_instr", id_instr, hin);
      end
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: got pc %0h want none", id_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", id_pc, e.pc);
          chk("sb_instr", id_instr, e.instr);
          chk("sb_opcode", id_opcode, e.instr[7:6]);
        end
      end
      hold = id_valid && !id_ready;
      hpc  = id_pc;
      hin  = id_instr;
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    lat   = 1;
    hold  = 1'b0;
    reset_n         = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = '0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    id_ready        = 1'b0;
    for (int i = 0; i < 256; i++)
      mem[i] = 8'(i);

    // streaming, latency 1
    do_reset(1, 1'b1);
    step(0, 8'd0, 1);
    chk("str_c1_valid", id_valid, 0);
    step(0, 8'd0, 1);
    chk("str_c2_valid", id_valid, 1);
    chk("str_c2_pc", id_pc, 0);
    step(0, 8'd0, 1);
    chk("str_c3_pc", id_pc, 1);
    repeat (6) step(0, 8'd0, 1);
    chk("str_c9_pc", id_pc, 7);

    // redirect coinciding with a response and a ready decode
    step(1, 8'h20, 1);
    chk("sim_valid", id_valid, 0);
    chk("sim_req", imem_req, 0);
    step(0, 8'd0, 1);
    chk("sim_t1_valid", id_valid, 0);
    chk("sim_t1_req", imem_req, 1);
    chk("sim_t1_addr", imem_addr, 8'h20);
    step(0, 8'd0, 1);
    chk("sim_t2_valid", id_valid, 0);
    step(0, 8'd0, 1);
    chk("sim_t3_pc", id_pc, 8'h20);

    // wrap through 0xFF
    repeat (3) step(0, 8'd0, 1);
    step(1, 8'hFE, 1);
    repeat (3) step(0, 8'd0, 1);
    chk("wrap_fe", id_pc, 8'hFE);
    step(0, 8'd0, 1);
    chk("wrap_ff", id_pc, 8'hFF);
    step(0, 8'd0, 1);
    chk("wrap_00", id_pc, 8'h00);
    repeat (5) step(0, 8'd0, 1);

    // backpressure
    do_reset(1, 1'b0);
    req_cnt = imem_req ? 1 : 0;
    repeat (12) begin
      step(0, 8'd0, 0);
      if (imem_req)
        req_cnt++;
    end
    chk("bp_reqs", req_cnt, 4);
    chk("bp_req_low", imem_req, 0);
    chk("bp_instr", id_instr, 0);
    step(0, 8'd0, 1);
    chk("bp_first_pc", id_pc, 0);
    repeat (3) step(0, 8'd0, 1);
    step(0, 8'd0, 1);
    chk("bp_pc4_valid", id_valid, 1);
    chk("bp_pc4", id_pc, 4);
    repeat (6) step(0, 8'd0, 1);

    // redirect with two reads in flight, latency 3
    do_reset(3, 1'b1);
    step(0, 8'd0, 1);
    step(1, 8'h40, 1);
    chk("stale_redir_req", imem_req, 0);
    step(0, 8'd0, 1);
    chk("stale_req_40", imem_addr, 8'h40);
    chk("stale_req_v", imem_req, 1);
    step(0, 8'd0, 1);
    step(0, 8'd0, 1);
    chk("stale_c5_valid", id_valid, 0);
    step(0, 8'd0, 1);
    chk("stale_c6_valid", id_valid, 0);
    step(0, 8'd0, 1);
    chk("stale_pc40", id_pc, 8'h40);
    step(0, 8'd0, 1);
    chk("stale_pc41", id_pc, 8'h41);
    repeat (6) step(0, 8'd0, 1);

    // nop handling
    mem[1] = 8'h80;
    mem[2] = 8'h40;
    do_reset(1, 1'b1);
    step(0, 8'd0, 1);
    step(0, 8'd0, 1);
    chk("nop_pc0", id_pc, 0);
    step(0, 8'd0, 1);
`ifdef FETCH_NOP_SQUASH_EN
    chk("nop_squashed", id_valid, 0);
`else
    chk("nop_pc1", id_pc, 1);
    chk("nop_op1", id_opcode, 2'b10);
`endif
    step(0, 8'd0, 1);
    chk("nop_pc2", id_pc, 2);
    repeat (4) step(0, 8'd0, 1);

    // randomized traffic against the scoreboard
    for (int i = 0; i < 256; i++)
      mem[i] = 8'($urandom);
    repeat (2) begin
      do_reset(int'($urandom_range(1, 3)), 1'b1);
      repeat (350)
        step($urandom_range(0, 19) == 0, 8'($urandom),
             $urandom_range(0, 9) < 7);
      repeat (10) step(0, 8'd0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
